// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected inference pipeline.
// Holds the sequencer state encoding and the default array sizes.
package nn_pkg;

    localparam int NN_NUM_LAYERS = 3;
    localparam int NN_MAX_INPUTS = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_ACTIVATE,
        ST_WRITEBACK,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/nn_step_counter.sv
// Loadable up-counter with enable; wraps to zero on terminal count.
// tc flags the enabled cycle on which count equals limit-1.
module nn_step_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign count = count_q;
    assign tc    = en && (count_q == limit - W'(1));

    // Next count: load wins, then advance or wrap on terminal count.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = tc ? '0 : count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer sequencer: clear, feed, drain, activate, write back per layer.
// Host sees start/busy/done; per-layer input counts latched on start.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_LAYERS  = NN_NUM_LAYERS,
    parameter int MAX_INPUTS  = NN_MAX_INPUTS,
    parameter int MAC_LATENCY = 2,
    parameter int CNT_W       = $clog2(MAX_INPUTS + 1),
    parameter int LAYER_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        feed_stall,
    input  logic [NUM_LAYERS*CNT_W-1:0] cfg_num_inputs,
    output logic                        busy,
    output logic                        done,
    output logic [LAYER_W-1:0]          layer_idx,
    output logic [CNT_W-1:0]            feed_idx,
    output logic                        neuron_clear,
    output logic                        acc_en,
    output logic                        act_en,
    output logic                        wb_en
);

    localparam int DRN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY + 1) : 1;
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0]   MAX_N      = CNT_W'(MAX_INPUTS);

    seq_state_t state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [NUM_LAYERS-1:0][CNT_W-1:0] cfg_q, cfg_d;

    logic [CNT_W-1:0] cur_n;
    logic [CNT_W-1:0] raw_n;
    logic             feed_en;
    logic             feed_load;
    logic             feed_tc;
    logic             drn_en;
    logic             drn_load;
    logic             drn_tc;
    logic [DRN_W-1:0] drn_cnt_unused;

    assign cur_n     = cfg_q[layer_q];
    assign feed_en   = (state_q == ST_FEED) && !feed_stall;
    assign feed_load = abort || (state_q != ST_FEED);
    assign drn_en    = (state_q == ST_DRAIN);
    assign drn_load  = abort || (state_q != ST_DRAIN);

    nn_step_counter #(.W(CNT_W)) u_feed_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (feed_load),
        .load_val ('0),
        .en       (feed_en),
        .limit    (cur_n),
        .count    (feed_idx),
        .tc       (feed_tc)
    );

    nn_step_counter #(.W(DRN_W)) u_drain_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (drn_load),
        .load_val ('0),
        .en       (drn_en),
        .limit    (DRN_W'(MAC_LATENCY)),
        .count    (drn_cnt_unused),
        .tc       (drn_tc)
    );

    // Next state, layer index and latched (clamped) configuration.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        cfg_d   = cfg_q;
        raw_n   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    for (int i = 0; i < NUM_LAYERS; i++) begin
                        raw_n    = cfg_num_inputs[i*CNT_W +: CNT_W];
                        cfg_d[i] = (raw_n > MAX_N) ? MAX_N : raw_n;
                    end
                    layer_d = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = (cur_n != '0) ? ST_FEED : ST_DRAIN;
            end
            ST_FEED: begin
                if (feed_tc) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drn_tc) state_d = ST_ACTIVATE;
            end
            ST_ACTIVATE: begin
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                if (layer_q == LAST_LAYER) begin
                    state_d = ST_DONE;
                end else begin
                    layer_d = layer_q + LAYER_W'(1);
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: begin
                layer_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                layer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            layer_d = '0;
            state_d = ST_IDLE;
        end
    end

    // Sequencer state, layer index and configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            cfg_q   <= cfg_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign layer_idx    = layer_q;
    assign neuron_clear = (state_q == ST_CLEAR);
    assign acc_en       = feed_en;
    assign act_en       = (state_q == ST_ACTIVATE);
    assign wb_en        = (state_q == ST_WRITEBACK);

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer.
// Cycle k is the interval after the k-th edge of a scenario.
module tb_nn_layer_sequencer;

    localparam int CNT_W   = 7;
    localparam int LAYER_W = 2;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;
    logic feed_stall;
    logic [3*CNT_W-1:0] cfg_num_inputs;
    logic busy;
    logic done;
    logic [LAYER_W-1:0] layer_idx;
    logic [CNT_W-1:0] feed_idx;
    logic neuron_clear;
    logic acc_en;
    logic act_en;
    logic wb_en;

    int n_chk  = 0;
    int n_fail = 0;

    logic s_busy, s_done, s_clr, s_acc, s_act, s_wb;
    logic [LAYER_W-1:0] s_layer;
    logic [CNT_W-1:0] s_fidx;

    nn_layer_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .feed_stall     (feed_stall),
        .cfg_num_inputs (cfg_num_inputs),
        .busy           (busy),
        .done           (done),
        .layer_idx      (layer_idx),
        .feed_idx       (feed_idx),
        .neuron_clear   (neuron_clear),
        .acc_en         (acc_en),
        .act_en         (act_en),
        .wb_en          (wb_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, sample outputs mid-cycle, advance.
    task automatic step(input logic s, input logic a,
                        input logic fs, input logic rs);
        start      = s;
        abort      = a;
        feed_stall = fs;
        reset      = rs;
        @(negedge clk);
        s_busy  = busy;
        s_done  = done;
        s_clr   = neuron_clear;
        s_acc   = acc_en;
        s_act   = act_en;
        s_wb    = wb_en;
        s_layer = layer_idx;
        s_fidx  = feed_idx;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3*CNT_W-1:0] pack3(input int n2, input int n1,
                                                input int n0);
        return {CNT_W'(n2), CNT_W'(n1), CNT_W'(n0)};
    endfunction

    initial begin
        logic [3*CNT_W-1:0] basic;
        logic exp_acc;
        int acc0, acc1, max0, act1_c, done_c, ndone, nclr, first_done;

        basic          = pack3(2, 3, 4);
        cfg_num_inputs = basic;
        start = 0; abort = 0; feed_stall = 0; reset = 1;
        @(posedge clk);
        #1;

        // Reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("rst_busy", s_busy, 0);
        check("rst_outs", {s_done, s_clr, s_acc, s_act, s_wb}, 0);
        check("rst_idx", {s_layer, s_fidx}, 0);

        // Basic run; cfg changed after start must not matter
        for (int c = 0; c <= 26; c++) begin
            cfg_num_inputs = (c >= 1) ? pack3(9, 9, 9) : basic;
            step(c == 0, 0, 0, 0);
            exp_acc = (c >= 2 && c <= 5) || (c >= 11 && c <= 13) ||
                      (c >= 19 && c <= 20);
            check("b_acc", s_acc, exp_acc);
            if (exp_acc)
                check("b_fidx", s_fidx,
                      (c <= 5) ? c - 2 : (c <= 13) ? c - 11 : c - 19);
            check("b_busy", s_busy, (c >= 1 && c <= 25));
            check("b_done", s_done, (c == 25));
            check("b_clr", s_clr, (c == 1 || c == 10 || c == 18));
            check("b_act", s_act, (c == 8 || c == 16 || c == 23));
            check("b_wb", s_wb, (c == 9 || c == 17 || c == 24));
            if (c == 9)  check("b_wb_l0", s_layer, 0);
            if (c == 17) check("b_wb_l1", s_layer, 1);
            if (c == 24) check("b_wb_l2", s_layer, 2);
        end
        cfg_num_inputs = basic;

        // Stall in FEED cycles 3-4; stall in DRAIN ignored
        for (int c = 0; c <= 28; c++) begin
            step(c == 0, 0, (c == 3 || c == 4 || c == 9), 0);
            if (c == 3 || c == 4) begin
                check("s_acc_lo", s_acc, 0);
                check("s_fidx_hold", s_fidx, 1);
            end
            if (c == 5) check("s_acc_resume", {s_acc, s_fidx}, {1'b1, 7'd1});
            if (c == 11) check("s_wb_l0", {s_wb, s_layer}, {1'b1, 2'd0});
            if (c == 25) check("s_no_done25", s_done, 0);
            if (c == 27) check("s_done27", s_done, 1);
            if (c == 28) check("s_idle28", s_busy, 0);
        end

        // Zero-count layer and clamp
        cfg_num_inputs = pack3(1, 0, 70);
        acc0 = 0; acc1 = 0; max0 = -1; act1_c = -1; done_c = -1;
        for (int c = 0; c <= 85; c++) begin
            step(c == 0, 0, 0, 0);
            if (s_acc && s_layer == 0) begin
                acc0++;
                max0 = s_fidx;
            end
            if (s_acc && s_layer == 1) acc1++;
            if (s_act && s_layer == 1) act1_c = c;
            if (s_done) done_c = c;
            if (c == 66) check("z_fidx_back0", s_fidx, 0);
        end
        check("z_acc0_cnt", acc0, 64);
        check("z_acc0_last", max0, 63);
        check("z_acc1_cnt", acc1, 0);
        check("z_act1_cyc", act1_c, 73);
        check("z_done_cyc", done_c, 81);
        cfg_num_inputs = basic;

        // Abort in cycle 6, restart in cycle 8
        ndone = 0; done_c = -1;
        for (int c = 0; c <= 35; c++) begin
            step(c == 0 || c == 8, c == 6, 0, 0);
            if (s_done) begin
                ndone++;
                done_c = c;
            end
            if (c == 7) begin
                check("a_busy7", s_busy, 0);
                check("a_strobes7", {s_done, s_clr, s_acc, s_act, s_wb}, 0);
                check("a_idx7", {s_layer, s_fidx}, 0);
            end
            if (c == 9) check("a_clr9", {s_clr, s_layer}, {1'b1, 2'd0});
            if (c == 17) check("a_wb17", {s_wb, s_layer}, {1'b1, 2'd0});
        end
        check("a_ndone", ndone, 1);
        check("a_done_cyc", done_c, 33);

        // start held through the run
        ndone = 0; nclr = 0; first_done = -1; done_c = -1;
        for (int c = 0; c <= 55; c++) begin
            step(c <= 40, 0, 0, 0);
            if (s_done) begin
                ndone++;
                if (first_done < 0) first_done = c;
                done_c = c;
            end
            if (s_clr && c <= 26) nclr++;
            if (c == 26) check("h_idle26", s_busy, 0);
            if (c == 27) check("h_clr27", {s_clr, s_layer}, {1'b1, 2'd0});
        end
        check("h_nclr", nclr, 3);
        check("h_ndone", ndone, 2);
        check("h_done1", first_done, 25);
        check("h_done2", done_c, 51);

        // start and abort together in IDLE
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("sa_busy", s_busy, 0);
        check("sa_clr", s_clr, 0);

        // Reset mid-inference
        for (int c = 0; c <= 5; c++) begin
            step(c == 0, 0, 0, c == 4);
            if (c == 4) check("r_busy4", s_busy, 1);
            if (c == 5) begin
                check("r_busy5", s_busy, 0);
                check("r_outs5", {s_done, s_clr, s_acc, s_act, s_wb}, 0);
                check("r_idx5", {s_layer, s_fidx}, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
